// File: rtl/pixel_dispatcher_if.sv
// pixel_dispatcher_if: engine launch/collect bus and outgoing pixel stream
interface pixel_dispatcher_if #(
  parameter int NUM_ENG = 4,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int COUNT_W = 24
);
  logic [NUM_ENG-1:0]         eng_start;
  logic [NUM_ENG-1:0]         buf_clr;
  logic [$clog2(WIDTH)-1:0]   eng_x;
  logic [$clog2(HEIGHT)-1:0]  eng_y;
  logic [NUM_ENG-1:0]         eng_flag;
  logic [NUM_ENG*COUNT_W-1:0] eng_rgb;
  logic                       pix_valid;
  logic                       pix_ready;
  logic [COUNT_W-1:0]         pix_data;
  logic                       pix_sof;
  logic                       pix_eol;
  logic                       pix_last;
  modport master (
    output eng_start, buf_clr, eng_x, eng_y, pix_valid, pix_data, pix_sof, pix_eol, pix_last,
    input  eng_flag, eng_rgb, pix_ready
  );
  modport slave (
    input  eng_start, buf_clr, eng_x, eng_y, pix_valid, pix_data, pix_sof, pix_eol, pix_last,
    output eng_flag, eng_rgb, pix_ready
  );
endinterface

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: round-robin pixel launch to engines, in-order result collection
module pixel_dispatcher #(
  parameter int NUM_ENG = 4,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int COUNT_W = 24
) (
  input  logic aclk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  pixel_dispatcher_if.master bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int PW = $clog2(NUM_ENG);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2;
  logic [1:0]         state;
  logic [NUM_ENG-1:0] slot_busy;
  logic [PW-1:0]      d, o;
  logic [XW-1:0]      x, ox;
  logic [YW-1:0]      y, oy;
  logic               disp, coll, hs, go, fin;
  always_comb begin
    disp = state == ACTIVE && !slot_busy[d];
    coll = slot_busy[o] && bus.eng_flag[o] && (!bus.pix_valid || bus.pix_ready);
    hs   = bus.pix_valid && bus.pix_ready;
    go   = state == IDLE && start && !done;
    fin  = state == FLUSH && hs && bus.pix_last;
  end
  assign bus.eng_start = disp ? NUM_ENG'(1) << d : '0;
  assign bus.buf_clr   = bus.eng_start;
  assign bus.eng_x     = x;
  assign bus.eng_y     = y;
  assign busy          = state != IDLE;
  // Slot state is purely registered: a slot freed at an edge is only visible as FREE afterwards.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      done          <= 1'b0;
      slot_busy     <= '0;
      d             <= '0;
      o             <= '0;
      x             <= '0;
      y             <= '0;
      ox            <= '0;
      oy            <= '0;
      bus.pix_valid <= 1'b0;
      bus.pix_data  <= '0;
      bus.pix_sof   <= 1'b0;
      bus.pix_eol   <= 1'b0;
      bus.pix_last  <= 1'b0;
    end else begin
      done      <= fin;
      slot_busy <= (slot_busy | bus.eng_start) & ~(coll ? NUM_ENG'(1) << o : '0);
      if (go) state <= ACTIVE;
      else if (fin) state <= IDLE;
      else if (disp && x == XMAX && y == YMAX) state <= FLUSH;
      if (disp) begin
        d <= d + 1'b1;
        x <= x == XMAX ? '0 : x + 1'b1;
        if (x == XMAX) y <= y == YMAX ? '0 : y + 1'b1;
      end
      if (coll) begin
        bus.pix_valid <= 1'b1;
        bus.pix_data  <= bus.eng_rgb[int'(o)*COUNT_W +: COUNT_W];
        bus.pix_sof   <= ox == '0 && oy == '0;
        bus.pix_eol   <= ox == XMAX;
        bus.pix_last  <= ox == XMAX && oy == YMAX;
        o             <= o + 1'b1;
        ox            <= ox == XMAX ? '0 : ox + 1'b1;
        if (ox == XMAX) oy <= oy == YMAX ? '0 : oy + 1'b1;
      end else if (hs) begin
        bus.pix_valid <= 1'b0;
        bus.pix_sof   <= 1'b0;
        bus.pix_eol   <= 1'b0;
        bus.pix_last  <= 1'b0;
      end
      if (go) begin
        d  <= '0;
        o  <= '0;
        x  <= '0;
        y  <= '0;
        ox <= '0;
        oy <= '0;
      end
    end
  end
endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb_pixel_dispatcher: engine/buffer model plus scoreboard for the pixel stream
module tb_pixel_dispatcher;
  localparam int NE = 4, W = 4, H = 2, CW = 24;
  logic aclk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done;
  pixel_dispatcher_if #(.NUM_ENG(NE), .WIDTH(W), .HEIGHT(H), .COUNT_W(CW)) bus();
  pixel_dispatcher #(.NUM_ENG(NE), .WIDTH(W), .HEIGHT(H), .COUNT_W(CW)) dut (
    .aclk(aclk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
  );
  always #5 aclk = ~aclk;

  typedef struct packed {logic [CW-1:0] data; logic sof, eol, last;} pix_t;
  typedef struct {int lat0, lato, bp_at, bp_len; bit stale, extra, sod; int exp_px, exp_done;} scen_t;
  pix_t sb[$];
  int   dq[$];
  int   errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // engine + result buffer model: flag rises lat cycles after launch, cleared by buf_clr
  logic [NE-1:0] flag = '0, fresh = '0, inject = '0;
  logic [CW-1:0] rgb [NE] = '{default: '0};
  logic [CW-1:0] val [NE] = '{default: '0};
  int cnt [NE] = '{default: 0};
  int lat0 = 3, lato = 3;
  always @(posedge aclk)
    for (int i = 0; i < NE; i++) begin
      if (inject[i]) begin
        flag[i]  <= 1'b1;
        fresh[i] <= 1'b0;
        rgb[i]   <= 24'hBAD;
      end
      if (bus.buf_clr[i]) begin
        flag[i]  <= 1'b0;
        fresh[i] <= 1'b0;
      end
      if (bus.eng_start[i]) begin
        cnt[i] <= i == 0 ? lat0 : lato;
        val[i] <= CW'(int'(bus.eng_y) * W + int'(bus.eng_x));
      end else if (cnt[i] > 0) begin
        cnt[i] <= cnt[i] - 1;
        if (cnt[i] == 1) begin
          flag[i]  <= 1'b1;
          fresh[i] <= 1'b1;
          rgb[i]   <= val[i];
        end
      end
    end
  assign bus.eng_flag = flag;
  for (genvar g = 0; g < NE; g++) begin : g_rgb
    assign bus.eng_rgb[g*CW +: CW] = rgb[g];
  end

  pix_t cur;
  assign cur = {bus.pix_data, bus.pix_sof, bus.pix_eol, bus.pix_last};
  int disp_idx = 0, hs_cnt = 0, done_cnt = 0, me;
  logic [NE-1:0] pending = '0;
  bit presented = 0, hold = 0;
  pix_t held;
  always @(negedge aclk) begin
    #1;
    if (rst) begin
      hold = 0;
      presented = 0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("done_while_idle", {63'd0, busy}, 0);
      end
      if (bus.pix_valid && !presented) begin
        presented = 1;
        if (dq.size() == 0) chk("present_without_dispatch", 1, 0);
        else begin
          me = dq.pop_front();
          chk("present_fresh_flag", {63'd0, fresh[me]}, 1);
          pending[me] = 1'b0;
        end
      end
      if (hold) chk("hold_stable", {bus.pix_valid, cur}, {1'b1, held});
      if (|bus.eng_start) begin
        me = disp_idx % NE;
        chk("dispatch", {bus.eng_start, bus.buf_clr, bus.eng_x, bus.eng_y, pending[me], disp_idx < W*H},
            {4'(1 << me), 4'(1 << me), 2'(disp_idx % W), 1'(disp_idx / W), 1'b0, 1'b1});
        pending[me] = 1'b1;
        dq.push_back(me);
        disp_idx++;
      end
      if (bus.pix_valid && bus.pix_ready) begin
        hs_cnt++;
        presented = 0;
        if (sb.size() == 0) chk("pixel_unexpected", 1, 0);
        else chk("pixel", cur, sb.pop_front());
      end
      hold = bus.pix_valid && !bus.pix_ready;
      held = cur;
    end
  end

  task automatic prep_frame();
    disp_idx = 0;
    hs_cnt   = 0;
    done_cnt = 0;
    dq.delete();
    pending = '0;
    for (int i = 0; i < W*H; i++) sb.push_back({CW'(i), i == 0, i % W == W-1, i == W*H-1});
  endtask

  task automatic run_frame(input scen_t s);
    bit fin = 0;
    lat0 = s.lat0;
    lato = s.lato;
    prep_frame();
    if (s.stale) begin
      @(negedge aclk) inject = 4'b0100;
      @(negedge aclk) inject = '0;
    end
    @(negedge aclk) start = 1'b1;
    @(posedge aclk) #1;
    chk("first_dispatch", {busy, bus.eng_start, bus.eng_x, bus.eng_y}, {1'b1, 4'b0001, 2'd0, 1'd0});
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge aclk);
      bus.pix_ready = !(c >= s.bp_at && c < s.bp_at + s.bp_len);
      start = s.extra && busy && (c % 3 == 1);
      if (done) begin
        fin = 1;
        start = s.sod;
      end
    end
    if (!fin) chk("frame_timeout", 0, 1);
    if (s.sod) begin
      @(posedge aclk) #1;
      chk("start_with_done_ignored", {63'd0, busy}, 0);
    end
    @(negedge aclk);
    start = 1'b0;
    bus.pix_ready = 1'b1;
    repeat (6) @(negedge aclk);
    #2;
    chk("pixels", hs_cnt, s.exp_px);
    chk("dones", done_cnt, s.exp_done);
    chk("sb_drained", sb.size(), 0);
    chk("idle_after", {63'd0, busy}, 0);
  endtask

  scen_t tbl [5];
  initial begin
    int c;
    tbl[0] = '{lat0: 3,  lato: 3, bp_at: 0, bp_len: 0,  stale: 0, extra: 0, sod: 0, exp_px: 8, exp_done: 1};
    tbl[1] = '{lat0: 20, lato: 2, bp_at: 0, bp_len: 0,  stale: 0, extra: 0, sod: 0, exp_px: 8, exp_done: 1};
    tbl[2] = '{lat0: 3,  lato: 3, bp_at: 6, bp_len: 10, stale: 0, extra: 0, sod: 0, exp_px: 8, exp_done: 1};
    tbl[3] = '{lat0: 3,  lato: 3, bp_at: 0, bp_len: 0,  stale: 1, extra: 0, sod: 0, exp_px: 8, exp_done: 1};
    tbl[4] = '{lat0: 4,  lato: 5, bp_at: 0, bp_len: 0,  stale: 0, extra: 1, sod: 1, exp_px: 8, exp_done: 1};
    bus.pix_ready = 1'b1;
    repeat (2) @(negedge aclk);
    #2;
    chk("reset_outputs", {busy, done, bus.eng_start, bus.buf_clr, bus.eng_x, bus.eng_y, bus.pix_valid,
        bus.pix_sof, bus.pix_eol, bus.pix_last}, 0);
    chk("reset_data", {40'd0, bus.pix_data}, 0);
    @(negedge aclk) rst = 1'b0;
    for (int i = 0; i < 5; i++) run_frame(tbl[i]);
    lat0 = 3;
    lato = 3;
    prep_frame();
    @(negedge aclk) start = 1'b1;
    @(negedge aclk) start = 1'b0;
    c = 0;
    while (hs_cnt < 3 && c < 200) begin
      @(negedge aclk);
      #2;
      c++;
    end
    chk("reached_3_pixels", {63'd0, hs_cnt >= 3}, 1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_outputs", {busy, done, bus.eng_start, bus.buf_clr, bus.pix_valid, bus.pix_sof,
        bus.pix_eol, bus.pix_last}, 0);
    sb.delete();
    @(negedge aclk) #3 rst = 1'b0;
    run_frame(tbl[0]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
